// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with registered reads, optional zero entry and flush sweep.
// Define RF_BYPASS_EN to forward same-cycle write data to a read of the same address.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] AddrA,
    output logic [DATA_W-1:0] DataA,
    output logic              ValidA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] AddrB,
    output logic [DATA_W-1:0] DataB,
    output logic              ValidB,
    input  logic              WrC,
    input  logic [ADDR_W-1:0] AddrC,
    input  logic [DATA_W-1:0] DataC,
    input  logic              Flush,
    output logic              Ready,
    output logic              WrErr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              valid_a_q, valid_a_d;
    logic              valid_b_q, valid_b_d;
    logic              ready_q, ready_d;
    logic              wr_err_q, wr_err_d;
    logic              wr_ok;

    // A write lands only in IDLE, not on the flush-start cycle, and never to a hardwired zero entry.
    assign wr_ok = (state_q == IDLE) && WrC && !Flush && !(ZERO_REG && (AddrC == '0));

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mem_d     = mem_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        wr_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (RdEnA) begin
                    valid_a_d = 1'b1;
                    data_a_d  = mem_q[AddrA];
`ifdef RF_BYPASS_EN
                    if (wr_ok && (AddrC == AddrA)) data_a_d = DataC;
`endif
                    if (ZERO_REG && (AddrA == '0)) data_a_d = '0;
                end
                if (RdEnB) begin
                    valid_b_d = 1'b1;
                    data_b_d  = mem_q[AddrB];
`ifdef RF_BYPASS_EN
                    if (wr_ok && (AddrC == AddrB)) data_b_d = DataC;
`endif
                    if (ZERO_REG && (AddrB == '0)) data_b_d = '0;
                end
                if (wr_ok) mem_d[AddrC] = DataC;
                if (Flush) begin
                    state_d  = SWEEP;
                    idx_d    = '0;
                    wr_err_d = WrC;
                end
            end
            SWEEP: begin
                mem_d[idx_q] = '0;
                idx_d        = idx_q + 1'b1;
                wr_err_d     = WrC;
                if (idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the storage array is cleared on
    // reset because software relies on every entry reading zero afterwards.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mem_q     <= '{default: '0};
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            ready_q   <= 1'b1;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mem_q     <= mem_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            ready_q   <= ready_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign DataA  = data_a_q;
    assign DataB  = data_b_q;
    assign ValidA = valid_a_q;
    assign ValidB = valid_b_q;
    assign Ready  = ready_q;
    assign WrErr  = wr_err_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param at default parameters (32 x 32, zero entry on).
module tb_reg_file_param;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RdEnA, RdEnB, WrC, Flush;
    logic [4:0]  AddrA, AddrB, AddrC;
    logic [31:0] DataC;
    logic [31:0] DataA, DataB;
    logic        ValidA, ValidB, Ready, WrErr;

    int n_checks = 0;
    int n_errors = 0;
    int low_cycles;
    logic [31:0] exp_same;

    reg_file_param dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .RdEnA  (RdEnA),
        .AddrA  (AddrA),
        .DataA  (DataA),
        .ValidA (ValidA),
        .RdEnB  (RdEnB),
        .AddrB  (AddrB),
        .DataB  (DataB),
        .ValidB (ValidB),
        .WrC    (WrC),
        .AddrC  (AddrC),
        .DataC  (DataC),
        .Flush  (Flush),
        .Ready  (Ready),
        .WrErr  (WrErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        RdEnA = 1'b0; RdEnB = 1'b0; WrC = 1'b0; Flush = 1'b0;
        AddrA = '0; AddrB = '0; AddrC = '0; DataC = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        WrC = 1'b1; AddrC = a; DataC = d;
        tick();
        WrC = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        RdEnA = 1'b1; AddrA = a; RdEnB = 1'b1; AddrB = b;
        tick();
        RdEnA = 1'b0; RdEnB = 1'b0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_ready", Ready, 1);
        check("rst_valid_a", ValidA, 0);
        check("rst_data_a", DataA, 0);
        check("rst_wrerr", WrErr, 0);

        // Read of a cleared entry.
        RdEnA = 1'b1; AddrA = 5'd7;
        tick();
        RdEnA = 1'b0;
        check("rd7_data", DataA, 0);
        check("rd7_valid", ValidA, 1);
        check("rd7_ready", Ready, 1);

        // Write then dual-port read of the same address.
        do_write(5'd5, 32'hDEADBEEF);
        check("wr5_wrerr", WrErr, 0);
        do_read(5'd5, 5'd5);
        check("rd5_data_a", DataA, 32'hDEADBEEF);
        check("rd5_data_b", DataB, 32'hDEADBEEF);
        check("rd5_valid_a", ValidA, 1);
        check("rd5_valid_b", ValidB, 1);
        tick();
        check("hold_valid_a", ValidA, 0);
        check("hold_data_a", DataA, 32'hDEADBEEF);

        // Hardwired zero entry.
        do_write(5'd0, 32'h1234);
        check("zero_wrerr", WrErr, 0);
        do_read(5'd0, 5'd5);
        check("zero_data_a", DataA, 0);
        check("zero_data_b", DataB, 32'hDEADBEEF);

        // Same-cycle read and write of one address.
        do_write(5'd9, 32'h11);
        WrC = 1'b1; AddrC = 5'd9; DataC = 32'h22;
        RdEnA = 1'b1; AddrA = 5'd9;
        tick();
        WrC = 1'b0; RdEnA = 1'b0;
`ifdef RF_BYPASS_EN
        exp_same = 32'h22;
`else
        exp_same = 32'h11;
`endif
        check("rw9_same_cycle", DataA, exp_same);
        do_read(5'd9, 5'd9);
        check("rw9_later_a", DataA, 32'h22);
        check("rw9_later_b", DataB, 32'h22);

        // Fill every entry with nonzero data, spot-check, then flush.
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'hA5000000 | 32'(i));
        do_read(5'd3, 5'd31);
        check("fill3", DataA, 32'hA5000003);
        check("fill31", DataB, 32'hA500001F);

        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        low_cycles = 0;
        while (!Ready && low_cycles < 40) begin
            low_cycles++;
            if (low_cycles == 5) begin
                WrC = 1'b1; AddrC = 5'd3; DataC = 32'hBAD0BAD0;
                RdEnA = 1'b1; AddrA = 5'd31;
            end else begin
                WrC = 1'b0; RdEnA = 1'b0;
            end
            tick();
            if (low_cycles == 5) begin
                check("sweep_wrerr", WrErr, 1);
                check("sweep_valid_a", ValidA, 0);
                check("sweep_data_hold", DataA, 32'hA5000003);
            end
            if (low_cycles == 6) check("sweep_wrerr_pulse", WrErr, 0);
        end
        WrC = 1'b0; RdEnA = 1'b0;
        check("sweep_len", 32'(low_cycles), 32);
        for (int i = 0; i < 32; i += 2) begin
            do_read(5'(i), 5'(i + 1));
            check($sformatf("flush_a%0d", i), DataA, 0);
            check($sformatf("flush_b%0d", i + 1), DataB, 0);
        end

        // Reset in the middle of a sweep.
        do_write(5'd9, 32'h33);
        do_write(5'd12, 32'h44);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        repeat (9) tick();
        Reset = 1'b1; RdEnA = 1'b1; AddrA = 5'd12;
        tick();
        Reset = 1'b0; RdEnA = 1'b0;
        check("midrst_ready", Ready, 1);
        check("midrst_valid_a", ValidA, 0);
        check("midrst_data_a", DataA, 0);
        do_read(5'd9, 5'd12);
        check("midrst_e9", DataA, 0);
        check("midrst_e12", DataB, 0);
        check("midrst_valid_b", ValidB, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
